// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell swept LSB-first across WIDTH bits.
// Operands in and the result out each use a valid/ready handshake.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  fulladder u_fa (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .cin (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_nxt = w_s;
    end else begin : g_wn
      assign w_res_nxt = {w_s, r_res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (clear) w_state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (clear) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (in_valid) begin
              r_a_sr  <= a;
              r_b_sr  <= b;
              r_carry <= cin;
              r_cnt   <= '0;
            end
          end
          RUN: begin
            r_res_sr <= w_res_nxt;
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CW'(1);
            // result regs load only here so they hold through IDLE
            if (w_last) begin
              r_sum  <= w_res_nxt;
              r_cout <= w_c;
              r_ovf  <= r_carry ^ w_c;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus corner sequences.
// A second WIDTH=1 instance covers the single-bit build.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic [0:0] sum1;
  logic       cout1;
  logic       ovf1;
  logic       busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    start_op(v.a, v.b, v.cin);
    wait_done(lat);
    check("latency", lat, 8);
    check("sum", int'(sum), int'(v.sum));
    check("cout", int'(cout), int'(v.cout));
    check("ovf", int'(ovf), int'(v.ovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_done", int'(in_ready), 1);
    check("out_valid_after_done", int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // backpressure in DONE
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = 8'(8'hA0 + k);
      b = 8'(8'h0F ^ k);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum", int'(sum), 'h96);
      check("bp_cout", int'(cout), 0);
      check("bp_ovf", int'(ovf), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    check("idle_hold_sum", int'(sum), 'h96);

    // clear at cnt=3
    start_op(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_clear_busy", int'(busy), 1);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check("clear_in_ready", int'(in_ready), 1);
    check("clear_busy", int'(busy), 0);
    check("clear_out_valid", int'(out_valid), 0);
    check("clear_sum_held", int'(sum), 'h96);
    // clear beats in_valid in IDLE
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    check("clear_no_accept_busy", int'(busy), 0);
    check("clear_no_accept_ready", int'(in_ready), 1);
    run_op(vecs[4]);

    // async reset mid-RUN
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_sum", int'(sum), 0);
    check("arst_cout", int'(cout), 0);
    check("arst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) check("arst_spurious_valid", int'(out_valid), 0);
    end
    run_op(vecs[5]);

    // WIDTH=1 instance
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("w1_busy", int'(busy1), 1);
    check("w1_not_valid_yet", int'(out_valid1), 0);
    @(posedge clk);
    @(negedge clk);
    check("w1_out_valid", int'(out_valid1), 1);
    check("w1_sum", int'(sum1), 1);
    check("w1_cout", int'(cout1), 1);
    check("w1_ovf", int'(ovf1), 0);
    @(posedge clk);
    @(negedge clk);
    check("w1_in_ready", int'(in_ready1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It time-multiplexes a single 1-bit full-adder cell (fulladder, inputs a, b, cin; outputs s, c) across WIDTH-bit operands, LSB first.
- Accepts operand pairs on a valid/ready input handshake and presents the sum, carry-out and signed-overflow flag on a valid/ready output handshake.
- Used wherever area matters more than latency: one adder cell plus shift registers replaces a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8: operand/sum width in bits. Legal range is WIDTH >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort. Returns the block to IDLE, discarding any operation in flight.
- in_valid, input, 1: operands a, b and cin are valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in for bit 0.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- sum, output, WIDTH: a + b + cin, modulo 2^WIDTH.
- cout, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: two's-complement overflow, defined as the carry into MSB XOR the carry out of MSB.
- busy, output, 1: high in RUN.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; ovf=0; internal shift registers, carry register and bit counter all cleared.
- Exactly one full-adder instance. Its inputs are a_sr[0], b_sr[0] and carry_q. No other adder logic is permitted.
- Bit counter width is $clog2(WIDTH+1).
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On the accept edge (in_valid && in_ready): a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0, state<=RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, res_sr <= {fa.s, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; carry_q<=fa.c; cnt<=cnt+1.
  - When cnt==WIDTH-1: ovf_q <= carry_q ^ fa.c, cout_q <= fa.c, state<=DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - sum, cout and ovf are stable and held for as long as out_ready=0.
  - On out_valid && out_ready: state<=IDLE. The next operation is not accepted in the same cycle; the earliest next accept is the following edge.
- Latency:
  - out_valid rises WIDTH edges after the accept edge.
  - Throughput is at most one operation per WIDTH+2 cycles.
- Output hold: sum, cout and ovf keep the last result through IDLE until the next DONE. Only out_valid qualifies them.
- clear: takes priority over every transition.
  - From any state, the next state is IDLE, out_valid=0 and cnt=0.
  - The sum, cout and ovf registers are unchanged.
  - clear together with in_valid in IDLE: the operation is not accepted.
- in_valid while not in IDLE: ignored. Operands are sampled only on the accept edge; a and b may change freely during RUN.
- Reset mid-RUN or mid-DONE: immediate return to reset values, with no spurious out_valid after release.
- WIDTH=1: RUN lasts one cycle; ovf = cin ^ cout of that single bit.
- State encoding: 2 bits, IDLE=0, RUN=1, DONE=2. The unused code 3 recovers to IDLE on the next edge.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> after 8 cycles out_valid=1, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> out_valid stays 1, sum/cout/ovf stable, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- Assert clear at cnt=3 of an operation -> IDLE next edge, out_valid never asserted. An immediate follow-up of 0x12+0x34 -> sum=0x46 with correct 8-cycle latency.
- Drop rst_n asynchronously mid-RUN (between edges) -> outputs take reset values immediately. Release and run 0x01+0x01 -> sum=0x02.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0, with out_valid one edge after accept.
